ppu_frame_store: RTL and testbench
==================================

# ppu_frame_store

Parametrised, double-buffered pixel sink for the PPU pixel pipeline. Pops pixels from the pixel FIFO during mode 3 and discards the fine-scroll pixels at the start of each line. Writes the visible pixels into the back bank of a ping-pong frame store, and swaps banks at frame completion. A registered read port gives the display/host side tear-free access to the front bank.

## Interface
Parameters:
- WIDTH, 160, visible pixels per line
- HEIGHT, 144, visible lines per frame
- PIX_BITS, 2, bits per stored pixel (color index)
- ADDR_W, $clog2(WIDTH*HEIGHT), linear pixel address width
- XW, $clog2(WIDTH), x counter width; YW, $clog2(HEIGHT), y counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pixel_transfer_en  in  1  PPU mode 3 active
- fifo_empty  in  1  pixel FIFO empty
- fifo_color  in  PIX_BITS  head-of-FIFO pixel color
- fifo_read_en  out  1  pop FIFO head this cycle
- scx_fine  in  3  SCX[2:0], sampled on flush
- flush  in  1  start-of-line restart
- pixel_x  out  XW  current write x (to fetcher)
- pixel_y  out  YW  current write line
- line_done  out  1  one-cycle pulse, last pixel of a line written
- frame_done  out  1  one-cycle pulse, last pixel of a frame written
- front_bank  out  1  bank currently exposed on read port
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  linear address y*WIDTH+x in front bank
- rd_data  out  PIX_BITS  read result

## Operation
- consume = pixel_transfer_en && !fifo_empty && !flush. fifo_read_en = consume, combinational.
- Priority: reset > flush > consume.
- flush: x←0, discard←scx_fine, line_done←0, frame_done←0. y and banks are unchanged. The FIFO is not popped.
- consume with discard≠0: discard←discard−1. Nothing is written and x is held.
- consume with discard=0:
  - Write fifo_color to back bank (!front_bank) at y*WIDTH+x, computed at ADDR_W bits without truncation loss.
  - x≠WIDTH−1: x←x+1.
  - x=WIDTH−1: x←0, line_done←1, y←y+1.
  - x=WIDTH−1 and y=HEIGHT−1: additionally y←0, frame_done←1, front_bank toggles.
- Pulses self-clear the following cycle.
- Read port:
  - rd_en samples rd_addr and returns the front-bank content on rd_data next cycle.
  - rd_addr ≥ WIDTH*HEIGHT returns 0.
  - rd_data holds its value when rd_en=0.
- The reader never observes the back bank. A read issued in the same cycle as the swap returns the old front bank. Reads on the following cycle return the new front bank.
- Write and read target opposite banks, so the memory needs no read/write collision handling.
- Stored pixels are not cleared by reset. Contents are undefined until first written.

## Timing
- Reset values: pixel_x=0, pixel_y=0, discard=0, line_done=0, frame_done=0, front_bank=0, rd_data=0. fifo_read_en follows its combinational equation.
- Write latency: pixel visible in memory 1 cycle after the consume edge. It is readable only after the next swap.
- Read latency: 1 cycle, registered.
- Throughput: 1 pixel/cycle while FIFO is non-empty. Stalls on empty leave all state unchanged.
- pixel_transfer_en low: no pop, no state change.
- Reset mid-line or mid-frame: counters and front_bank return to reset values asynchronously. A partial back-bank frame is abandoned.
- line_done and frame_done assert in the same cycle on the final pixel. front_bank changes on that same edge.

## Test plan
- WIDTH=160, HEIGHT=144, scx_fine=5, flush then 165 pixels streamed -> first 5 not written. Pixel 6 is written to address 0. line_done pulses on pixel 165 and pixel_y becomes 1.
- Stream a full frame with a known pattern, front_bank=0 -> frame_done pulses with line_done on the last pixel. front_bank becomes 1. Reads of addresses 0, 159, and 23039 return the pattern one cycle after rd_en.
- fifo_empty toggled every other cycle during a line -> fifo_read_en only when non-empty. pixel_x advances exactly once per pop.
- flush asserted with FIFO non-empty and transfer enabled -> fifo_read_en=0 that cycle. pixel_x=0. Discard is reloaded.
- rd_en asserted in the swap cycle and the cycle after -> first returns old-bank data, second returns new-bank data. rd_addr=23040 returns 0.
- Reset asserted at x=80 -> all outputs at reset values immediately. The next frame starts at address 0 in bank 1.

Source files
------------

// File: rtl/ppu_frame_store.sv
// ppu_frame_store
// Double-buffered pixel sink for the PPU pixel pipeline. During mode 3 it pops
// pixels from the pixel FIFO, drops the SCX fine-scroll pixels at the start of
// each line, and writes the visible pixels into the back bank of a ping-pong
// frame store. The banks swap when the last pixel of a frame is written. A
// registered read port exposes only the front bank, so readers never see a
// frame that is still being drawn.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pixel_transfer_en     PPU mode 3 active
//   fifo_empty/fifo_color pixel FIFO status and head-of-FIFO color
//   fifo_read_en          pop FIFO head this cycle (combinational)
//   scx_fine, flush       start-of-line restart, loads the discard count
//   pixel_x, pixel_y      current write position (to fetcher)
//   line_done, frame_done one-cycle pulses on the last pixel of a line/frame
//   front_bank            bank currently exposed on the read port
//   rd_en, rd_addr        read request, linear address y*WIDTH+x
//   rd_data               registered read result (0 for out-of-range)
module ppu_frame_store #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 144,
  parameter int PIX_BITS = 2,
  parameter int ADDR_W   = $clog2(WIDTH*HEIGHT),
  parameter int XW       = $clog2(WIDTH),
  parameter int YW       = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pixel_transfer_en,
  input  logic                fifo_empty,
  input  logic [PIX_BITS-1:0] fifo_color,
  output logic                fifo_read_en,
  input  logic [2:0]          scx_fine,
  input  logic                flush,
  output logic [XW-1:0]       pixel_x,
  output logic [YW-1:0]       pixel_y,
  output logic                line_done,
  output logic                frame_done,
  output logic                front_bank,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [PIX_BITS-1:0] rd_data
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [XW-1:0]   X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [2:0]          discard;
  logic                consume;
  logic                write_en;
  logic [ADDR_W-1:0]   wr_addr;

  logic [PIX_BITS-1:0] bank0 [DEPTH];
  logic [PIX_BITS-1:0] bank1 [DEPTH];

  assign consume      = pixel_transfer_en && !fifo_empty && !flush;
  assign fifo_read_en = consume;
  assign write_en     = consume && (discard == 3'd0);

  // Operands widened to ADDR_W before the multiply so y*WIDTH cannot overflow.
  assign wr_addr = ADDR_W'(pixel_y) * ADDR_W'(WIDTH) + ADDR_W'(pixel_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x    <= '0;
      pixel_y    <= '0;
      discard    <= 3'd0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      front_bank <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (flush) begin
        pixel_x <= '0;
        discard <= scx_fine;
      end else if (consume) begin
        if (discard != 3'd0) begin
          discard <= discard - 3'd1;
        end else if (pixel_x != X_LAST) begin
          pixel_x <= pixel_x + XW'(1);
        end else begin
          pixel_x   <= '0;
          line_done <= 1'b1;
          if (pixel_y == Y_LAST) begin
            pixel_y    <= '0;
            frame_done <= 1'b1;
            front_bank <= ~front_bank;
          end else begin
            pixel_y <= pixel_y + YW'(1);
          end
        end
      end
    end
  end

  // Writes go to the back bank only; the read port only sees the front bank,
  // so the two ports never touch the same bank and need no collision logic.
  always_ff @(posedge clk) begin
    if (write_en && !reset) begin
      if (front_bank) bank0[wr_addr] <= fifo_color;
      else            bank1[wr_addr] <= fifo_color;
    end
  end

  // front_bank is sampled before it toggles, so a read in the swap cycle
  // still returns the old front bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_addr} >= DEPTH_EXT) rd_data <= '0;
      else if (front_bank)              rd_data <= bank1[rd_addr];
      else                              rd_data <= bank0[rd_addr];
    end
  end

endmodule

// File: tb/tb_ppu_frame_store.sv
// tb_ppu_frame_store
// Bench for ppu_frame_store. A driver issues one cycle of stimulus at a time,
// advances a linear-position reference model and pushes the expected
// post-edge state into a queue; a negedge monitor pops and compares.
module tb_ppu_frame_store;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 144;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pixel_transfer_en = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [1:0]        fifo_color = '0;
  logic              fifo_read_en;
  logic [2:0]        scx_fine = '0;
  logic              flush = 1'b0;
  logic [XW-1:0]     pixel_x;
  logic [YW-1:0]     pixel_y;
  logic              line_done;
  logic              frame_done;
  logic              front_bank;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [1:0]        rd_data;

  ppu_frame_store #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .pixel_transfer_en(pixel_transfer_en), .fifo_empty(fifo_empty),
    .fifo_color(fifo_color), .fifo_read_en(fifo_read_en),
    .scx_fine(scx_fine), .flush(flush),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_done(line_done), .frame_done(frame_done), .front_bank(front_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    int       x;
    int       y;
    bit       fb;
    bit       ld;
    bit       fd;
    bit       rd_chk;
    bit [1:0] rd_val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Reference model: position as a linear pixel index within the frame.
  int       m_pos = 0;
  int       m_disc = 0;
  bit       m_fb = 0;
  bit [1:0] m_rd = 0;
  bit       m_rd_ok = 1;
  int       pops = 0;
  int       frames = 0;
  int       mmem [2][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      chk("pixel_x", int'(pixel_x), mon_e.x);
      chk("pixel_y", int'(pixel_y), mon_e.y);
      chk("front_bank", int'(front_bank), int'(mon_e.fb));
      chk("line_done", int'(line_done), int'(mon_e.ld));
      chk("frame_done", int'(frame_done), int'(mon_e.fd));
      if (mon_e.rd_chk) chk("rd_data", int'(rd_data), int'(mon_e.rd_val));
    end
  end

  task automatic step(input bit te, input bit fe, input bit [1:0] col, input bit fl,
                      input bit [2:0] sc, input bit re, input int ra);
    exp_t e;
    bit   cons;
    int   v;
    @(posedge clk); #1;
    pixel_transfer_en = te; fifo_empty = fe; fifo_color = col;
    flush = fl; scx_fine = sc; rd_en = re; rd_addr = ADDR_W'(ra);
    cons = te && !fe && !fl;
    #1;
    chk("fifo_read_en", int'(fifo_read_en), int'(cons));
    if (re) begin
      if (ra >= DEPTH) begin
        m_rd = 2'd0; m_rd_ok = 1;
      end else begin
        v = mmem[m_fb][ra];
        m_rd_ok = (v >= 0);
        m_rd = 2'(v);
      end
    end
    e.rd_chk = m_rd_ok;
    e.rd_val = m_rd;
    e.ld = 0; e.fd = 0;
    if (fl) begin
      m_pos = m_pos - (m_pos % WIDTH);
      m_disc = sc;
    end else if (cons) begin
      pops++;
      if (m_disc > 0) m_disc--;
      else begin
        mmem[1 - m_fb][m_pos] = col;
        m_pos++;
        if (m_pos % WIDTH == 0) e.ld = 1;
        if (m_pos == DEPTH) begin
          m_pos = 0; e.fd = 1; m_fb = ~m_fb; frames++;
        end
      end
    end
    e.x = m_pos % WIDTH;
    e.y = m_pos / WIDTH;
    e.fb = m_fb;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input bit re, input int ra);
    step(0, 1, 2'd0, 0, 3'd0, re, ra);
  endtask

  // Streams pixels with pattern (pos*7+f)&3 until max_pops pops or a frame ends.
  task automatic run(input int f, input int max_pops, input int stall_pct,
                     input bit toggle, input int read_pct);
    int  p0 = pops;
    int  f0 = frames;
    int  it = 0;
    bit  te, fe, re;
    int  ra;
    while ((pops - p0) < max_pops && frames == f0) begin
      if (it > 4 * max_pops + 200) begin
        total++; bad++;
        $display("FAIL run_timeout: got %0d pops expected %0d", pops - p0, max_pops);
        break;
      end
      fe = toggle ? (it % 2 == 1) : ($urandom_range(99) < stall_pct);
      te = !(stall_pct > 0 && $urandom_range(99) < 3);
      re = ($urandom_range(99) < read_pct);
      ra = $urandom_range(DEPTH + 3);
      if (m_pos == DEPTH - 1 && m_disc == 0) begin
        re = 1; ra = 0;
      end
      step(te, fe, 2'((m_pos * 7 + f) % 4), 0, 3'd0, re, ra);
      it++;
    end
  endtask

  task automatic reset_checks();
    chk("rst_pixel_x", int'(pixel_x), 0);
    chk("rst_pixel_y", int'(pixel_y), 0);
    chk("rst_front_bank", int'(front_bank), 0);
    chk("rst_line_done", int'(line_done), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_fifo_read_en", int'(fifo_read_en),
        int'(pixel_transfer_en && !fifo_empty && !flush));
  endtask

  task automatic do_reset();
    @(posedge clk); @(negedge clk); #1;
    pixel_transfer_en = 1; fifo_empty = 0; flush = 0; rd_en = 0;
    reset = 1; #1;
    reset_checks();
    m_pos = 0; m_disc = 0; m_fb = 0; m_rd = 0; m_rd_ok = 1;
    repeat (2) @(posedge clk);
    #1;
    pixel_transfer_en = 0; fifo_empty = 1;
    reset = 0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mmem[b][a] = -1;

    pixel_transfer_en = 1; fifo_empty = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    pixel_transfer_en = 0; fifo_empty = 1;
    reset = 0;

    // flush with data present: no pop, discard loaded with 5
    step(1, 0, 2'd3, 1, 3'd5, 0, 0);
    run(1, 165, 0, 0, 0);
    // every-other-cycle empty FIFO for one line
    run(1, WIDTH, 0, 1, 10);
    // mid-line flush, then finish the frame with random stalls and reads
    run(1, 30, 5, 0, 10);
    step(1, 0, 2'd1, 1, 3'd3, 0, 0);
    run(1, DEPTH + 200, 5, 0, 20);

    // frame 1 now in front bank 1
    idle(1, 0);
    idle(1, 159);
    idle(1, 23039);
    idle(1, 23040);
    idle(0, 0);
    idle(1, 160);

    // frame 2 into bank 0; swap-cycle read is forced inside run
    run(2, DEPTH + 200, 0, 0, 20);
    idle(1, 0);
    idle(1, 23039);

    // frame 3 abandoned by reset at x=80
    run(4, 80, 5, 0, 10);
    do_reset();
    run(3, DEPTH + 200, 0, 0, 20);
    idle(1, 0);
    idle(1, 159);
    idle(1, 23039);
    idle(1, 23040);
    idle(0, 0);
    idle(0, 0);

    @(negedge clk); @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    chk("frames_seen", frames, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
